// File: rtl/ahb_slave_sram.sv
// AHB slave with a local byte-lane word memory, configurable wait states and two-cycle ERROR.
// Decodes size/alignment/range at address acceptance; forwards same-word write bytes into zero-wait reads.
module ahb_slave_sram #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int MEM_DEPTH      = 256,
  parameter int WAIT_STATES    = 0
) (
  input  logic                          ahb_clk_in,
  input  logic                          ahb_rst_in,
  input  logic                          ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0]     ahb_addr_in,
  input  logic [1:0]                    ahb_trans_in,
  input  logic [2:0]                    ahb_burst_in,
  input  logic [2:0]                    ahb_size_in,
  input  logic                          ahb_write_in,
  input  logic [AHB_DATA_WIDTH/8-1:0]   ahb_strb_in,
  input  logic [AHB_DATA_WIDTH-1:0]     ahb_wdata_in,
  input  logic                          ahb_ready_in,
  output logic                          ahb_readyout_out,
  output logic                          ahb_resp_out,
  output logic [AHB_DATA_WIDTH-1:0]     ahb_rdata_out
);

  localparam int NB = AHB_DATA_WIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AHB_ADDR_WIDTH:0] MEM_BYTES = (AHB_ADDR_WIDTH + 1)'(MEM_DEPTH * NB);
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                    state_reg;
  logic                      ready_reg;
  logic                      resp_reg;
  logic [2:0]                cnt_reg;
  logic [AHB_ADDR_WIDTH-1:0] addr_reg;
  logic [2:0]                size_reg;
  logic                      write_reg;
  logic [IW-1:0]             idx_reg;

  logic                      can_accept;
  logic                      accept;
  logic                      size_err;
  logic                      align_err;
  logic                      range_err;
  logic                      addr_err;
  logic [AHB_ADDR_WIDTH-1:0] align_mask;
  logic [IW-1:0]             idx_in;
  logic [NB-1:0]             mask_in;
  logic [NB-1:0]             mask_reg;
  logic                      wr_en;
  logic [NB-1:0]             wr_strb;
  logic                      rd_load;
  logic [IW-1:0]             rd_idx;
  logic [NB-1:0]             rd_mask;
  logic                      fwd;
  logic                      unused_bits;

  // True when byte lane 'lane' lies inside the beat starting at lane offset 'off'.
  function automatic logic lane_hit(input logic [LW-1:0] off, input logic [2:0] size, input int lane);
    int lo;
    int hi;
    lo = int'(off);
    hi = lo + (1 << size);
    return (lane >= lo) && (lane < hi);
  endfunction

  assign can_accept = (state_reg == S_IDLE) || (state_reg == S_DATA) || (state_reg == S_ERR2);
  assign accept     = can_accept && ahb_sel_in && ahb_ready_in && ahb_trans_in[1];

  assign size_err   = (32'd8 << ahb_size_in) > 32'(AHB_DATA_WIDTH);
  assign align_mask = (AHB_ADDR_WIDTH'(1) << ahb_size_in) - AHB_ADDR_WIDTH'(1);
  assign align_err  = |(ahb_addr_in & align_mask);
  assign range_err  = {1'b0, ahb_addr_in} >= MEM_BYTES;
  assign addr_err   = size_err || align_err || range_err;
  assign idx_in     = ahb_addr_in[LW +: IW];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_mask
      assign mask_in[gi]  = lane_hit(ahb_addr_in[LW-1:0], ahb_size_in, gi);
      assign mask_reg[gi] = lane_hit(addr_reg[LW-1:0], size_reg, gi);
    end
  endgenerate

  // Write commits on the completing data-phase edge; a reset on that edge abandons it.
  assign wr_en   = !ahb_rst_in && (state_reg == S_DATA) && write_reg;
  assign wr_strb = ahb_strb_in & mask_reg;

  // Zero-wait reads load at acceptance; otherwise on the last wait cycle.
  assign rd_load = ZERO_WAIT ? (accept && !addr_err && !ahb_write_in)
                             : ((state_reg == S_WAIT) && (cnt_reg == 3'd0) && !write_reg);
  assign rd_idx  = ZERO_WAIT ? idx_in  : idx_reg;
  assign rd_mask = ZERO_WAIT ? mask_in : mask_reg;
  assign fwd     = wr_en && (rd_idx == idx_reg);

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [MEM_DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge ahb_clk_in) begin
        if (wr_en && wr_strb[gi]) begin
          mem[idx_reg] <= ahb_wdata_in[8*gi +: 8];
        end
      end

      always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
          rd_byte_reg <= 8'd0;
        end else if (rd_load) begin
          if (!rd_mask[gi]) begin
            rd_byte_reg <= 8'd0;
          end else if (fwd && wr_strb[gi]) begin
            rd_byte_reg <= ahb_wdata_in[8*gi +: 8];
          end else begin
            rd_byte_reg <= mem[rd_idx];
          end
        end
      end

      assign ahb_rdata_out[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      state_reg <= S_IDLE;
      ready_reg <= 1'b1;
      resp_reg  <= 1'b0;
      cnt_reg   <= 3'd0;
      addr_reg  <= '0;
      size_reg  <= 3'd0;
      write_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        S_WAIT: begin
          if (cnt_reg == 3'd0) begin
            state_reg <= S_DATA;
            ready_reg <= 1'b1;
            resp_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        S_ERR1: begin
          state_reg <= S_ERR2;
          ready_reg <= 1'b1;
          resp_reg  <= 1'b1;
        end
        default: begin
          // S_IDLE, S_DATA and S_ERR2 all open a new address phase
          if (accept) begin
            addr_reg  <= ahb_addr_in;
            size_reg  <= ahb_size_in;
            write_reg <= ahb_write_in;
            idx_reg   <= idx_in;
            if (addr_err) begin
              state_reg <= S_ERR1;
              ready_reg <= 1'b0;
              resp_reg  <= 1'b1;
            end else if (!ZERO_WAIT) begin
              state_reg <= S_WAIT;
              cnt_reg   <= WAIT_LOAD;
              ready_reg <= 1'b0;
              resp_reg  <= 1'b0;
            end else begin
              state_reg <= S_DATA;
              ready_reg <= 1'b1;
              resp_reg  <= 1'b0;
            end
          end else begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b1;
            resp_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ahb_readyout_out = ready_reg;
  assign ahb_resp_out     = resp_reg;

  assign unused_bits = ^{ahb_burst_in, ahb_trans_in[0], addr_reg};

endmodule

// File: tb/tb_ahb_slave_sram.sv
// Scoreboard bench: a zero-wait and a three-wait instance share one bus driver and a byte-level memory model.
module tb_ahb_slave_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        cur_dut;
  logic [31:0] addr;
  logic [1:0]  trans;
  logic [2:0]  burst;
  logic [2:0]  size;
  logic        write;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic        sel0, sel3;
  logic        ready0, resp0, ready3, resp3;
  logic [31:0] rdata0, rdata3;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          idle;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  txn_t issue_q[$];
  exp_t sb_q[$];
  logic [7:0] model_mem [1024];

  assign sel0 = sel & ~cur_dut;
  assign sel3 = sel & cur_dut;

  always #5 clk = ~clk;

  ahb_slave_sram #(.WAIT_STATES(0)) u_dut0 (
    .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel0), .ahb_addr_in(addr),
    .ahb_trans_in(trans), .ahb_burst_in(burst), .ahb_size_in(size), .ahb_write_in(write),
    .ahb_strb_in(strb), .ahb_wdata_in(wdata), .ahb_ready_in(ready0),
    .ahb_readyout_out(ready0), .ahb_resp_out(resp0), .ahb_rdata_out(rdata0)
  );

  ahb_slave_sram #(.WAIT_STATES(3)) u_dut3 (
    .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel3), .ahb_addr_in(addr),
    .ahb_trans_in(trans), .ahb_burst_in(burst), .ahb_size_in(size), .ahb_write_in(write),
    .ahb_strb_in(strb), .ahb_wdata_in(wdata), .ahb_ready_in(ready3),
    .ahb_readyout_out(ready3), .ahb_resp_out(resp3), .ahb_rdata_out(rdata3)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] lane_mask_of(input logic [31:0] a, input logic [2:0] sz);
    case (sz)
      3'd0:    return 4'b0001 << a[1:0];
      3'd1:    return 4'b0011 << a[1:0];
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic add(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [3:0] sb, input logic [31:0] wd);
    txn_t t;
    t.idle = 1'b0; t.wr = wr; t.addr = a; t.size = sz; t.strb = sb; t.wdata = wd;
    issue_q.push_back(t);
  endtask

  task automatic add_idle();
    txn_t t;
    t.idle = 1'b1; t.wr = 1'b0; t.addr = '0; t.size = '0; t.strb = '0; t.wdata = '0;
    issue_q.push_back(t);
  endtask

  // Predict the response for a transfer being driven now and update the model in bus order.
  function automatic exp_t predict(input txn_t t, input int ws);
    exp_t e;
    logic [3:0] lm;
    int base;
    e.wr    = t.wr;
    e.err   = (t.size > 3'd2) || ((t.addr & ((32'd1 << t.size) - 32'd1)) != 32'd0) || (t.addr >= 32'd1024);
    e.waits = e.err ? 1 : ws;
    e.rdata = '0;
    if (!e.err) begin
      lm   = lane_mask_of(t.addr, t.size);
      base = int'({t.addr[31:2], 2'b00});
      for (int k = 0; k < 4; k++) begin
        if (t.wr && t.strb[k] && lm[k]) model_mem[base + k] = t.wdata[8*k +: 8];
        if (!t.wr && lm[k]) e.rdata[8*k +: 8] = model_mem[base + k];
      end
    end
    return e;
  endfunction

  task automatic run_bus(input int max_cycles);
    txn_t t, dp_t;
    exp_t e;
    bit dp_valid, dp_start;
    int waits, n;
    logic rdy, rsp;
    logic [31:0] rd;
    dp_valid = 0; dp_start = 0; waits = 0; n = 0;
    dp_t = '{default: '0};
    while ((issue_q.size() > 0 || dp_valid) && n < max_cycles) begin
      @(negedge clk);
      n++;
      rdy = cur_dut ? ready3 : ready0;
      rsp = cur_dut ? resp3 : resp0;
      rd  = cur_dut ? rdata3 : rdata0;
      if (dp_start) begin
        wdata = dp_t.wdata;
        strb  = dp_t.strb;
        dp_start = 0;
      end
      if (dp_valid) begin
        if (!rdy) begin
          waits++;
          check_value("resp_in_wait", 32'(rsp), 32'(sb_q[0].err));
        end else begin
          e = sb_q.pop_front();
          $display("txn dut=%0d wr=%0b addr=0x%h size=%0d resp=%0b waits=%0d rdata=0x%h",
                   cur_dut ? 3 : 0, dp_t.wr, dp_t.addr, dp_t.size, rsp, waits, rd);
          check_value("resp", 32'(rsp), 32'(e.err));
          check_value("waits", 32'(waits), 32'(e.waits));
          if (!e.wr && !e.err) check_value("rdata", rd, e.rdata);
          dp_valid = 0;
          waits = 0;
        end
      end
      if (rdy) begin
        trans = 2'b00;
        if (issue_q.size() > 0) begin
          t = issue_q.pop_front();
          if (!t.idle) begin
            sel = 1'b1; addr = t.addr; size = t.size; write = t.wr; trans = 2'b10; burst = 3'd0;
            sb_q.push_back(predict(t, cur_dut ? 3 : 0));
            dp_t = t;
            dp_valid = 1;
            dp_start = 1;
          end
        end
      end
    end
    check_value("bus_done", 32'(issue_q.size() + sb_q.size()), 32'd0);
  endtask

  task automatic idle_check(input int cycles);
    trans = 2'b00;
    sel   = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_value("idle_ready", 32'(cur_dut ? ready3 : ready0), 32'd1);
      check_value("idle_resp", 32'(cur_dut ? resp3 : resp0), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'd0;
    rst = 1'b1; sel = 1'b0; cur_dut = 1'b0; addr = '0; trans = 2'b00; burst = '0;
    size = '0; write = 1'b0; strb = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check_value("rst_ready0", 32'(ready0), 32'd1);
    check_value("rst_resp0", 32'(resp0), 32'd0);
    check_value("rst_rdata0", rdata0, 32'd0);
    check_value("rst_ready3", 32'(ready3), 32'd1);
    check_value("rst_resp3", 32'(resp3), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // zero-wait instance: forwarding, byte lanes, errors, top word
    add(1, 32'h10, 3'd2, 4'hF, 32'hDEADBEEF);
    add(0, 32'h10, 3'd2, 4'h0, 32'h0);
    add_idle();
    add(0, 32'h10, 3'd2, 4'h0, 32'h0);
    add(1, 32'h4, 3'd2, 4'hF, 32'h11223344);
    add(0, 32'h4, 3'd2, 4'h0, 32'h0);
    add(1, 32'h4, 3'd2, 4'hF, 32'h00000000);
    add(1, 32'h7, 3'd0, 4'b1000, 32'hABCDEF01);
    add(0, 32'h4, 3'd2, 4'h0, 32'h0);
    add(1, 32'h8, 3'd2, 4'hF, 32'h55555555);
    add(1, 32'h8, 3'd1, 4'hF, 32'h12345678);
    add_idle();
    add(0, 32'h8, 3'd2, 4'h0, 32'h0);
    add(0, 32'hA, 3'd1, 4'h0, 32'h0);
    add(0, 32'h400, 3'd2, 4'h0, 32'h0);
    add(1, 32'h12, 3'd2, 4'hF, 32'hFFFFFFFF);
    add(1, 32'h10, 3'd3, 4'hF, 32'hFFFFFFFF);
    add(0, 32'h10, 3'd2, 4'h0, 32'h0);
    add(1, 32'h3FC, 3'd2, 4'hF, 32'hA5A50F0F);
    add(0, 32'h3FC, 3'd2, 4'h0, 32'h0);
    run_bus(400);
    idle_check(2);

    // three-wait instance
    cur_dut = 1'b1;
    add(1, 32'h20, 3'd2, 4'hF, 32'h0BADF00D);
    add(0, 32'h20, 3'd2, 4'h0, 32'h0);
    add_idle();
    add(0, 32'h400, 3'd2, 4'h0, 32'h0);
    add(0, 32'h22, 3'd1, 4'h0, 32'h0);
    run_bus(400);
    idle_check(3);

    // reset during the wait states of a write abandons it
    sel = 1'b1; addr = 32'h20; size = 3'd2; write = 1'b1; trans = 2'b10;
    @(negedge clk);
    check_value("wait_ready", 32'(ready3), 32'd0);
    trans = 2'b00; wdata = 32'hFFFFFFFF; strb = 4'hF; rst = 1'b1;
    @(negedge clk);
    check_value("midrst_ready", 32'(ready3), 32'd1);
    check_value("midrst_resp", 32'(resp3), 32'd0);
    check_value("midrst_rdata", rdata3, 32'd0);
    rst = 1'b0;
    add(0, 32'h20, 3'd2, 4'h0, 32'h0);
    run_bus(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
